// File: rtl/rom_share_arbiter_if.sv
// Bundle of the ROM download, CPU/VG read and ROM RAM signals around rom_share_arbiter.
// Latency: none, this is wiring only.
// Backpressure: the read ports use a req/ack handshake; the download port has none and flags dropped bytes.
//
// Port summary (slave = arbiter side):
//   dn_active/dn_wr/dn_addr/dn_data   HPS ioctl download stream
//   cpu_req/cpu_addr/cpu_ack/cpu_data CPU read port
//   vg_req/vg_addr/vg_ack/vg_data     vector generator read port
//   mem_addr/mem_we/mem_wdata/mem_rdata  single-port ROM RAM, 1-cycle read latency
//   core_reset_l                      active-low reset to the game core
//   dn_overrun                        sticky dropped-byte flag
interface rom_share_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              dn_active;
  logic              dn_wr;
  logic [15:0]       dn_addr;
  logic [7:0]        dn_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic              vg_req;
  logic [ADDR_W-1:0] vg_addr;
  logic              vg_ack;
  logic [7:0]        vg_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              core_reset_l;
  logic              dn_overrun;

  modport slave (
    input  dn_active, dn_wr, dn_addr, dn_data,
    input  cpu_req, cpu_addr, vg_req, vg_addr, mem_rdata,
    output cpu_ack, cpu_data, vg_ack, vg_data,
    output mem_addr, mem_we, mem_wdata, core_reset_l, dn_overrun
  );

  modport master (
    output dn_active, dn_wr, dn_addr, dn_data,
    output cpu_req, cpu_addr, vg_req, vg_addr, mem_rdata,
    input  cpu_ack, cpu_data, vg_ack, vg_data,
    input  mem_addr, mem_we, mem_wdata, core_reset_l, dn_overrun
  );
endinterface

// File: rtl/rom_share_arbiter.sv
// Shares one single-port synchronous ROM RAM between the ioctl download writer and the CPU / VG read ports.
// Latency: read req sampled at edge k -> ack after edge k+2, next grant at k+4; a buffered write takes 2 cycles.
// Backpressure: readers wait for ack (round-robin on contention, no reads during download); download bytes
//   arriving while the 1-entry write buffer is full and not draining are dropped and flagged in dn_overrun.
//
// Ports: clk_25 (single clock), RESET_L (async active-low), bus (rom_share_arbiter_if.slave, see interface).
module rom_share_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int ROM_BYTES = 16384,
  parameter int RST_HOLD  = 16
) (
  input logic                clk_25,
  input logic                RESET_L,
  rom_share_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, GAP} state_t;

  state_t            state;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              rd_vg;    // read in flight belongs to the VG port
  logic              last_vg;  // round-robin pointer: last read grant went to VG
  logic [CNT_W-1:0]  hold_cnt;

  logic in_range;
  logic drain;
  logic grant_rd;
  logic pick_vg;

  always_comb begin
    in_range = 32'(bus.dn_addr) < ROM_BYTES;
    drain    = (state == IDLE) && buf_full;
    grant_rd = (state == IDLE) && !buf_full && !bus.dn_active && (bus.cpu_req || bus.vg_req);
    // VG wins when it is alone, or when both ask and the CPU was served last.
    pick_vg  = bus.vg_req && (!bus.cpu_req || !last_vg);
  end

  // One-entry download write buffer. A drain and a fill on the same edge keep the new byte.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      buf_full       <= 1'b0;
      buf_addr       <= '0;
      buf_data       <= '0;
      bus.dn_overrun <= 1'b0;
    end else begin
      if (bus.dn_wr && in_range) begin
        if (!buf_full || drain) begin
          buf_full <= 1'b1;
          buf_addr <= bus.dn_addr[ADDR_W-1:0];
          buf_data <= bus.dn_data;
        end else begin
          bus.dn_overrun <= 1'b1;
        end
      end else if (drain) begin
        buf_full <= 1'b0;
      end
    end
  end

  // RAM access sequencer; all RAM-side and ack outputs are registered here.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      state         <= IDLE;
      rd_vg         <= 1'b0;
      last_vg       <= 1'b1;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_data  <= '0;
      bus.vg_ack    <= 1'b0;
      bus.vg_data   <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.vg_ack  <= 1'b0;
      bus.mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (buf_full) begin
            state         <= WR;
            bus.mem_addr  <= buf_addr;
            bus.mem_wdata <= buf_data;
            bus.mem_we    <= 1'b1;
          end else if (grant_rd) begin
            state        <= RD1;
            rd_vg        <= pick_vg;
            last_vg      <= pick_vg;
            bus.mem_addr <= pick_vg ? bus.vg_addr : bus.cpu_addr;
          end
        end
        WR:  state <= IDLE;
        RD1: state <= RD2;   // RAM registers the read on this edge
        RD2: begin
          state <= GAP;
          if (rd_vg) begin
            bus.vg_data <= bus.mem_rdata;
            bus.vg_ack  <= 1'b1;
          end else begin
            bus.cpu_data <= bus.mem_rdata;
            bus.cpu_ack  <= 1'b1;
          end
        end
        GAP:     state <= IDLE;   // gives the acked requester a cycle to drop req
        default: state <= IDLE;
      endcase
    end
  end

  // Core reset: low during download, then RST_HOLD cycles more and until the last write has retired.
  // Once released it stays high until the next download, so normal reads cannot pull it low.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      hold_cnt         <= CNT_W'(RST_HOLD);
      bus.core_reset_l <= 1'b0;
    end else if (bus.dn_active) begin
      hold_cnt         <= CNT_W'(RST_HOLD);
      bus.core_reset_l <= 1'b0;
    end else begin
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
      bus.core_reset_l <= bus.core_reset_l ||
                          ((hold_cnt <= CNT_W'(1)) && (state == IDLE) && !buf_full);
    end
  end

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Testbench for rom_share_arbiter: random CPU/VG reads, contention, download, overrun and reset.
// Expected read data comes from a byte-array model of ROM contents kept by the bench.
// A monitor pops per-port expectation queues whenever an ack appears.
module tb_rom_share_arbiter;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 16384;

  logic clk_25  = 1'b0;
  logic RESET_L = 1'b0;

  rom_share_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  rom_share_arbiter #(.ADDR_W(ADDR_W), .ROM_BYTES(DEPTH), .RST_HOLD(16)) dut (
    .clk_25 (clk_25),
    .RESET_L(RESET_L),
    .bus    (bus)
  );

  always #5 clk_25 = ~clk_25;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ROM RAM environment model (1-cycle synchronous read) ----------------
  function automatic logic [7:0] init_byte(input int i);
    if (i == 'h123) return 8'h5A;
    return 8'((i * 37) ^ (i >> 6) ^ 'hA5);
  endfunction

  logic [7:0] ram [0:DEPTH-1];
  bit         loaded;

  always @(posedge clk_25) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
      loaded <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // ---------------- reference model: what the ROM should contain ----------------
  logic [7:0] exp_mem [0:DEPTH-1];

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    bit vg;
    int cyc;
  } ack_t;

  logic [7:0] cpu_q[$];
  logic [7:0] vg_q[$];
  ack_t       ack_log[$];
  bit         last_vg = 1'b1;   // port served by the most recent ack

  always @(negedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      cpu_q.delete();
      vg_q.delete();
      last_vg = 1'b1;
    end else if (bus.cpu_ack || bus.vg_ack) begin
      check("single_ack", {31'd0, bus.cpu_ack & bus.vg_ack}, 0);
      if (bus.cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL cpu_spurious_ack actual=1 expected=0 at cyc %0d", cyc);
        end else begin
          check("cpu_data", {24'd0, bus.cpu_data}, {24'd0, cpu_q.pop_front()});
        end
        last_vg = 1'b0;
        ack_log.push_back('{vg: 1'b0, cyc: cyc});
      end
      if (bus.vg_ack) begin
        if (vg_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL vg_spurious_ack actual=1 expected=0 at cyc %0d", cyc);
        end else begin
          check("vg_data", {24'd0, bus.vg_data}, {24'd0, vg_q.pop_front()});
        end
        last_vg = 1'b1;
        ack_log.push_back('{vg: 1'b1, cyc: cyc});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_read(input bit is_vg, input logic [ADDR_W-1:0] a);
    int n;
    if (is_vg) begin
      bus.vg_addr = a; vg_q.push_back(exp_mem[a]); bus.vg_req = 1'b1;
    end else begin
      bus.cpu_addr = a; cpu_q.push_back(exp_mem[a]); bus.cpu_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk_25);
      n++;
    end while (!(is_vg ? bus.vg_ack : bus.cpu_ack) && n < 100);
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL read_timeout port_vg=%0d addr=0x%0h no ack in 100 cycles", is_vg, a);
    end
    if (is_vg) bus.vg_req = 1'b0;
    else       bus.cpu_req = 1'b0;
  endtask

  task automatic driver(input bit is_vg, input int count);
    repeat (count) begin
      repeat ($urandom_range(0, 4)) @(posedge clk_25);
      #1;
      do_read(is_vg, ADDR_W'($urandom));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_25);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ack"},   {31'd0, bus.cpu_ack}, 0);
    check({tag, "_vg_ack"},    {31'd0, bus.vg_ack}, 0);
    check({tag, "_cpu_data"},  {24'd0, bus.cpu_data}, 0);
    check({tag, "_vg_data"},   {24'd0, bus.vg_data}, 0);
    check({tag, "_mem_addr"},  {18'd0, bus.mem_addr}, 0);
    check({tag, "_mem_we"},    {31'd0, bus.mem_we}, 0);
    check({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 0);
    check({tag, "_core_rst"},  {31'd0, bus.core_reset_l}, 0);
    check({tag, "_overrun"},   {31'd0, bus.dn_overrun}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int bad;
    int base;
    bit first_vg;
    logic [ADDR_W-1:0] a_a, a_b, a_c;
    logic [7:0] d_a, d_b, d_c;

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_byte(i);
    bus.dn_active = 1'b0; bus.dn_wr = 1'b0; bus.dn_addr = '0; bus.dn_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.vg_req = 1'b0; bus.vg_addr = '0;

    // Reset state
    idle(3);
    check_all_zero("rst0");
    RESET_L = 1'b1;
    idle(40);
    check("core_reset_released", {31'd0, bus.core_reset_l}, 1);

    // Single read latency: req sampled at edge k, ack only after k+2
    @(posedge clk_25); #1;
    bus.cpu_addr = 14'h0123;
    cpu_q.push_back(exp_mem[14'h0123]);
    bus.cpu_req = 1'b1;
    @(posedge clk_25); @(negedge clk_25);
    check("lat_after_k", {31'd0, bus.cpu_ack}, 0);
    @(posedge clk_25); @(negedge clk_25);
    check("lat_after_k1", {31'd0, bus.cpu_ack}, 0);
    @(posedge clk_25); @(negedge clk_25);
    check("lat_after_k2", {31'd0, bus.cpu_ack}, 1);
    check("lat_data", {24'd0, bus.cpu_data}, 32'h5A);
    bus.cpu_req = 1'b0;
    idle(4);

    // Random concurrent traffic from both ports
    fork
      driver(1'b0, 30);
      driver(1'b1, 30);
    join
    idle(6);
    check("rand_cpu_q_drained", cpu_q.size(), 0);
    check("rand_vg_q_drained",  vg_q.size(), 0);

    // Reset asserted while a read sits in RD1: outputs clear at once, no ack afterwards
    @(posedge clk_25); #1;
    bus.cpu_addr = 14'h2AB;
    bus.cpu_req  = 1'b1;
    @(posedge clk_25); #3;
    RESET_L = 1'b0;
    #1;
    check_all_zero("rst_mid");
    bus.cpu_req = 1'b0;
    idle(2);
    RESET_L = 1'b1;
    idle(30);

    // Contention: both held high, acks alternate 4 cycles apart
    ack_log.delete();
    first_vg = !last_vg;
    @(posedge clk_25); #1;
    bus.cpu_addr = ADDR_W'($urandom);
    bus.vg_addr  = ADDR_W'($urandom);
    for (int i = 0; i < 4; i++) begin
      cpu_q.push_back(exp_mem[bus.cpu_addr]);
      vg_q.push_back(exp_mem[bus.vg_addr]);
    end
    bus.cpu_req = 1'b1;
    bus.vg_req  = 1'b1;
    n = 0;
    while (ack_log.size() < 8 && n < 200) begin
      @(negedge clk_25); #1;
      n++;
    end
    bus.cpu_req = 1'b0;
    bus.vg_req  = 1'b0;
    check("cont_ack_count", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size() && i < 8; i++) begin
      check($sformatf("cont_port_%0d", i), {31'd0, ack_log[i].vg}, {31'd0, first_vg ^ i[0]});
      if (i > 0) check($sformatf("cont_gap_%0d", i), ack_log[i].cyc - ack_log[i-1].cyc, 4);
    end
    idle(6);

    // Read held off while a download is active
    base = ack_log.size();
    @(posedge clk_25); #1;
    bus.dn_active = 1'b1;
    bus.cpu_addr  = 14'h1F00;
    cpu_q.push_back(exp_mem[14'h1F00]);
    bus.cpu_req   = 1'b1;
    idle(20);
    check("holdoff_no_ack", ack_log.size(), base);
    check("holdoff_pending", cpu_q.size(), 1);
    bus.dn_active = 1'b0;
    n = 0;
    do begin
      @(posedge clk_25); n++;
      @(negedge clk_25);
    end while (!bus.cpu_ack && n < 50);
    bus.cpu_req = 1'b0;
    check("holdoff_ack_cycles", n, 3);
    idle(30);

    // Full download, one byte every second cycle, then an out-of-range address
    bus.dn_active = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk_25); #1;
      bus.dn_wr   = 1'b1;
      bus.dn_addr = 16'(a);
      bus.dn_data = 8'($urandom);
      exp_mem[a]  = bus.dn_data;
      @(posedge clk_25); #1;
      bus.dn_wr   = 1'b0;
    end
    @(posedge clk_25); #1;
    bus.dn_wr   = 1'b1;
    bus.dn_addr = 16'h4000;
    bus.dn_data = ~exp_mem[0];
    @(posedge clk_25); #1;
    bus.dn_wr   = 1'b0;
    idle(3);
    check("dl_core_held", {31'd0, bus.core_reset_l}, 0);
    check("dl_no_overrun", {31'd0, bus.dn_overrun}, 0);
    bus.dn_active = 1'b0;
    n = 0;
    do begin
      @(posedge clk_25); #1;
      n++;
    end while (!bus.core_reset_l && n < 100);
    check("dl_core_release_cycles", n, 16);
    idle(2);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) bad++;
    check("dl_ram_mismatches", bad, 0);
    check("dl_addr_4000_dropped", {24'd0, ram[0]}, {24'd0, exp_mem[0]});
    for (int i = 0; i < 8; i++) do_read(1'b0, ADDR_W'($urandom));
    idle(4);

    // Overrun: three back-to-back bytes; the third finds the buffer full in WR and is dropped
    a_a = ADDR_W'($urandom_range(0, 'hFFF));
    a_b = a_a + 14'h1000;
    a_c = a_a + 14'h2000;
    d_a = ~exp_mem[a_a];
    d_b = ~exp_mem[a_b];
    d_c = ~exp_mem[a_c];
    bus.dn_active = 1'b1;
    @(posedge clk_25); #1;
    bus.dn_wr = 1'b1; bus.dn_addr = 16'(a_a); bus.dn_data = d_a;
    @(posedge clk_25); #1;
    bus.dn_addr = 16'(a_b); bus.dn_data = d_b;
    @(posedge clk_25); #1;
    bus.dn_addr = 16'(a_c); bus.dn_data = d_c;
    @(posedge clk_25); #1;
    bus.dn_wr = 1'b0;
    exp_mem[a_a] = d_a;
    exp_mem[a_b] = d_b;
    idle(4);
    check("ovr_flag", {31'd0, bus.dn_overrun}, 1);
    check("ovr_ram_a", {24'd0, ram[a_a]}, {24'd0, exp_mem[a_a]});
    check("ovr_ram_b", {24'd0, ram[a_b]}, {24'd0, exp_mem[a_b]});
    check("ovr_ram_c_dropped", {24'd0, ram[a_c]}, {24'd0, exp_mem[a_c]});
    bus.dn_active = 1'b0;
    idle(25);
    check("ovr_sticky", {31'd0, bus.dn_overrun}, 1);
    do_read(1'b1, a_c);
    do_read(1'b0, a_b);
    idle(4);
    RESET_L = 1'b0;
    #1;
    check("ovr_cleared_by_reset", {31'd0, bus.dn_overrun}, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
